// File: rtl/yt_phy_init_seq_if.sv
// -----------------------------------------------------------------------------
// yt_phy_init_seq_if
// Command/response bundle between the PHY init sequencer and the MDIO master
// driver.
//   start      : transaction request level (sequencer -> driver)
//   opcode     : 2'b01 write, 2'b10 read
//   phy_addr   : PHY MDIO address
//   reg_addr   : target PHY register
//   write_data : write payload
//   read_data  : read result (driver -> sequencer)
//   ready      : driver idle flag, mdc domain (driver -> sequencer)
// Modports: master = sequencer side, slave = driver side.
// -----------------------------------------------------------------------------
interface yt_phy_init_seq_if;
   logic        start;
   logic [1:0]  opcode;
   logic [4:0]  phy_addr;
   logic [4:0]  reg_addr;
   logic [15:0] write_data;
   logic [15:0] read_data;
   logic        ready;

   modport master (output start, opcode, phy_addr, reg_addr, write_data,
                   input  read_data, ready);
   modport slave  (input  start, opcode, phy_addr, reg_addr, write_data,
                   output read_data, ready);
endinterface

// File: rtl/yt_phy_init_seq.sv
// -----------------------------------------------------------------------------
// yt_phy_init_seq
// Management sequencer in front of the MDIO master driver. Drives the PHY
// hardware reset, releases the driver, writes a fixed init table (three
// register writes), then polls PHY status reg 0x11 and publishes link/speed.
//
// Ports:
//   clk          : system clock (same clock as the driver, mdc = clk/5)
//   rstn         : asynchronous active-low reset
//   mdio         : driver command bundle (yt_phy_init_seq_if.master)
//   phy_rstn     : PHY hardware reset, active low
//   reset_n_done : releases the driver's internal reset
//   init_done    : init table completed (held until reset)
//   link_up      : status reg 0x11 bit 10
//   speed        : status reg 0x11 bits 15:14
//   timeout_err  : sticky, any handshake phase timed out
//   id_err       : sticky, PHY ID mismatch (0 unless PHY_ID_CHECK_EN)
//
// Optional feature macro: PHY_ID_CHECK_EN -- when defined, reg 0x02 is read
// before the init table; a value other than 16'h4F51 halts the sequencer.
// -----------------------------------------------------------------------------
module yt_phy_init_seq #(
   parameter logic [4:0]  PHY_ADDR        = 5'h01,
   parameter logic [23:0] RST_LOW_CYCLES  = 24'd100000,
   parameter logic [23:0] RST_WAIT_CYCLES = 24'd200000,
   parameter logic [23:0] POLL_CYCLES     = 24'd1000000,
   parameter logic [15:0] TIMEOUT_CYCLES  = 16'd4000
) (
   input  logic              clk,
   input  logic              rstn,
   yt_phy_init_seq_if.master mdio,
   output logic              phy_rstn,
   output logic              reset_n_done,
   output logic              init_done,
   output logic              link_up,
   output logic [1:0]        speed,
   output logic              timeout_err,
   output logic              id_err
);

   localparam logic [1:0] OP_WR = 2'b01;
   localparam logic [1:0] OP_RD = 2'b10;

`ifdef PHY_ID_CHECK_EN
   typedef enum logic [2:0] {S_RST_LOW, S_RST_WAIT, S_ID_CHECK, S_INIT,
                             S_POLL_WAIT, S_POLL, S_ERR_HALT} top_st_t;
`else
   typedef enum logic [2:0] {S_RST_LOW, S_RST_WAIT, S_INIT,
                             S_POLL_WAIT, S_POLL} top_st_t;
`endif
   typedef enum logic [1:0] {T_IDLE, T_ARM, T_BUSY, T_DONE} t_st_t;

   top_st_t     r_top_st, w_top_nxt;
   t_st_t       r_t_st, w_t_nxt;
   logic [23:0] r_cnt, w_cnt_nxt;
   logic [15:0] r_tcnt, w_tcnt_nxt;
   logic [1:0]  r_idx, w_idx_nxt;
   logic        r_phy_rstn, w_phy_rstn_nxt;
   logic        r_rst_done, w_rst_done_nxt;
   logic        r_start, w_start_nxt;
   logic [1:0]  r_opcode, w_opcode_nxt;
   logic [4:0]  r_reg_addr, w_reg_addr_nxt;
   logic [15:0] r_wdata, w_wdata_nxt;
   logic        r_init_done, w_init_done_nxt;
   logic        r_link_up, w_link_up_nxt;
   logic [1:0]  r_speed, w_speed_nxt;
   logic        r_tmo_err, w_tmo_err_nxt;
   logic        r_rdy_m, r_rdy_s;
   logic        w_req, w_tdone;
   logic [1:0]  w_req_op;
   logic [4:0]  w_req_reg;
   logic [15:0] w_req_data;
   logic        w_unused_rd;
`ifdef PHY_ID_CHECK_EN
   logic        r_id_err, w_id_err_nxt;
`endif

   // Next-state and next-output logic for both FSMs
   always_comb begin
      w_top_nxt       = r_top_st;
      w_t_nxt         = r_t_st;
      w_cnt_nxt       = r_cnt;
      w_tcnt_nxt      = r_tcnt;
      w_idx_nxt       = r_idx;
      w_phy_rstn_nxt  = r_phy_rstn;
      w_rst_done_nxt  = r_rst_done;
      w_start_nxt     = r_start;
      w_opcode_nxt    = r_opcode;
      w_reg_addr_nxt  = r_reg_addr;
      w_wdata_nxt     = r_wdata;
      w_init_done_nxt = r_init_done;
      w_link_up_nxt   = r_link_up;
      w_speed_nxt     = r_speed;
      w_tmo_err_nxt   = r_tmo_err;
`ifdef PHY_ID_CHECK_EN
      w_id_err_nxt    = r_id_err;
`endif
      w_req           = 1'b0;
      w_req_op        = 2'b00;
      w_req_reg       = 5'd0;
      w_req_data      = 16'd0;
      w_tdone         = 1'b0;

      // Transaction requested by the top FSM in its current state
      case (r_top_st)
         S_INIT: begin
            w_req    = 1'b1;
            w_req_op = OP_WR;
            case (r_idx)
               2'd0:    begin w_req_reg = 5'h04; w_req_data = 16'h01E1; end
               2'd1:    begin w_req_reg = 5'h09; w_req_data = 16'h0200; end
               default: begin w_req_reg = 5'h00; w_req_data = 16'h1340; end
            endcase
         end
         S_POLL: begin
            w_req     = 1'b1;
            w_req_op  = OP_RD;
            w_req_reg = 5'h11;
         end
`ifdef PHY_ID_CHECK_EN
         S_ID_CHECK: begin
            w_req     = 1'b1;
            w_req_op  = OP_RD;
            w_req_reg = 5'h02;
         end
`endif
         default: ;
      endcase

      // Transaction sub-FSM; a timeout re-arms the same request
      case (r_t_st)
         T_IDLE: begin
            if (w_req) begin
               w_t_nxt    = T_ARM;
               w_tcnt_nxt = 16'd0;
            end
         end
         T_ARM: begin
            if (r_rdy_s) begin
               w_opcode_nxt   = w_req_op;
               w_reg_addr_nxt = w_req_reg;
               w_wdata_nxt    = w_req_data;
               w_start_nxt    = 1'b1;
               w_t_nxt        = T_BUSY;
               w_tcnt_nxt     = 16'd0;
            end
         end
         T_BUSY: begin
            if (!r_rdy_s) begin
               w_start_nxt = 1'b0;
               w_t_nxt     = T_DONE;
               w_tcnt_nxt  = 16'd0;
            end else if (r_tcnt == TIMEOUT_CYCLES - 16'd1) begin
               w_tmo_err_nxt = 1'b1;
               w_start_nxt   = 1'b0;
               w_t_nxt       = T_ARM;
               w_tcnt_nxt    = 16'd0;
            end else begin
               w_tcnt_nxt = r_tcnt + 16'd1;
            end
         end
         default: begin
            // T_DONE: entered with ready_s low, so ready_s high is the rising edge
            if (r_rdy_s) begin
               w_tdone = 1'b1;
               w_t_nxt = T_IDLE;
            end else if (r_tcnt == TIMEOUT_CYCLES - 16'd1) begin
               w_tmo_err_nxt = 1'b1;
               w_start_nxt   = 1'b0;
               w_t_nxt       = T_ARM;
               w_tcnt_nxt    = 16'd0;
            end else begin
               w_tcnt_nxt = r_tcnt + 16'd1;
            end
         end
      endcase

      // Top sequencing FSM
      case (r_top_st)
         S_RST_LOW: begin
            if (r_cnt == RST_LOW_CYCLES - 24'd1) begin
               w_top_nxt      = S_RST_WAIT;
               w_phy_rstn_nxt = 1'b1;
               w_cnt_nxt      = 24'd0;
            end else begin
               w_cnt_nxt = r_cnt + 24'd1;
            end
         end
         S_RST_WAIT: begin
            if (r_cnt == RST_WAIT_CYCLES - 24'd1) begin
               w_rst_done_nxt = 1'b1;
               w_cnt_nxt      = 24'd0;
`ifdef PHY_ID_CHECK_EN
               w_top_nxt      = S_ID_CHECK;
`else
               w_top_nxt      = S_INIT;
`endif
            end else begin
               w_cnt_nxt = r_cnt + 24'd1;
            end
         end
`ifdef PHY_ID_CHECK_EN
         S_ID_CHECK: begin
            if (w_tdone) begin
               if (mdio.read_data == 16'h4F51) begin
                  w_top_nxt = S_INIT;
               end else begin
                  w_id_err_nxt = 1'b1;
                  w_top_nxt    = S_ERR_HALT;
               end
            end
         end
`endif
         S_INIT: begin
            if (w_tdone) begin
               if (r_idx == 2'd2) begin
                  w_init_done_nxt = 1'b1;
                  w_top_nxt       = S_POLL_WAIT;
                  w_cnt_nxt       = 24'd0;
               end else begin
                  w_idx_nxt = r_idx + 2'd1;
               end
            end
         end
         S_POLL_WAIT: begin
            if (r_cnt == POLL_CYCLES - 24'd1) begin
               w_top_nxt = S_POLL;
               w_cnt_nxt = 24'd0;
            end else begin
               w_cnt_nxt = r_cnt + 24'd1;
            end
         end
         S_POLL: begin
            // Only a completed read updates link/speed; timeouts just retry
            if (w_tdone) begin
               w_link_up_nxt = mdio.read_data[10];
               w_speed_nxt   = mdio.read_data[15:14];
               w_top_nxt     = S_POLL_WAIT;
               w_cnt_nxt     = 24'd0;
            end
         end
         default: ;
      endcase
   end

   // State and output registers, ready synchronizer
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_top_st    <= S_RST_LOW;
         r_t_st      <= T_IDLE;
         r_cnt       <= 24'd0;
         r_tcnt      <= 16'd0;
         r_idx       <= 2'd0;
         r_phy_rstn  <= 1'b0;
         r_rst_done  <= 1'b0;
         r_start     <= 1'b0;
         r_opcode    <= 2'b00;
         r_reg_addr  <= 5'd0;
         r_wdata     <= 16'd0;
         r_init_done <= 1'b0;
         r_link_up   <= 1'b0;
         r_speed     <= 2'b00;
         r_tmo_err   <= 1'b0;
         r_rdy_m     <= 1'b0;
         r_rdy_s     <= 1'b0;
`ifdef PHY_ID_CHECK_EN
         r_id_err    <= 1'b0;
`endif
      end else begin
         r_top_st    <= w_top_nxt;
         r_t_st      <= w_t_nxt;
         r_cnt       <= w_cnt_nxt;
         r_tcnt      <= w_tcnt_nxt;
         r_idx       <= w_idx_nxt;
         r_phy_rstn  <= w_phy_rstn_nxt;
         r_rst_done  <= w_rst_done_nxt;
         r_start     <= w_start_nxt;
         r_opcode    <= w_opcode_nxt;
         r_reg_addr  <= w_reg_addr_nxt;
         r_wdata     <= w_wdata_nxt;
         r_init_done <= w_init_done_nxt;
         r_link_up   <= w_link_up_nxt;
         r_speed     <= w_speed_nxt;
         r_tmo_err   <= w_tmo_err_nxt;
         r_rdy_m     <= mdio.ready;
         r_rdy_s     <= r_rdy_m;
`ifdef PHY_ID_CHECK_EN
         r_id_err    <= w_id_err_nxt;
`endif
      end
   end

   // Only a few status bits are consumed in the default build
   assign w_unused_rd     = ^mdio.read_data;

   assign mdio.start      = r_start;
   assign mdio.opcode     = r_opcode;
   assign mdio.phy_addr   = PHY_ADDR;
   assign mdio.reg_addr   = r_reg_addr;
   assign mdio.write_data = r_wdata;
   assign phy_rstn        = r_phy_rstn;
   assign reset_n_done    = r_rst_done;
   assign init_done       = r_init_done;
   assign link_up         = r_link_up;
   assign speed           = r_speed;
   assign timeout_err     = r_tmo_err;
`ifdef PHY_ID_CHECK_EN
   assign id_err          = r_id_err;
`else
   assign id_err          = 1'b0;
`endif

endmodule

// File: doc/yt_phy_init_seq.md
# yt_phy_init_seq

Management sequencer directly upstream of the MDIO master driver in the yt_ctrl path. After reset it drives the PHY hardware reset and releases the driver's reset. It then issues a fixed list of PHY register writes, one transaction at a time, over the driver's start/ready handshake. Finally it polls the PHY-specific status register and publishes link and speed to the MAC side.

## Interface
- PHY_ADDR, 5'h01: PHY MDIO address placed on phy_addr for every transaction.
- RST_LOW_CYCLES, 24'd100000: clk cycles phy_rstn is held low after reset.
- RST_WAIT_CYCLES, 24'd200000: clk cycles from phy_rstn rise to reset_n_done rise.
- POLL_CYCLES, 24'd1000000: clk cycles between status polls.
- TIMEOUT_CYCLES, 16'd4000: maximum clk cycles per handshake phase.

Ports:
- clk, input, 1: system clock, the same clock feeding the driver (mdc = clk/5).
- rstn, input, 1: asynchronous active-low reset.
- phy_rstn, output, 1: PHY hardware reset, active low.
- reset_n_done, output, 1: releases the driver's internal reset.
- start, output, 1: transaction request level to the driver.
- opcode, output, 2: 2'b01 write, 2'b10 read.
- phy_addr, output, 5: equals PHY_ADDR.
- reg_addr, output, 5: target register.
- write_data, output, 16: write payload.
- read_data, input, 16: driver read result.
- ready, input, 1: driver idle flag (mdc domain).
- init_done, output, 1: init list completed.
- link_up, output, 1: status reg 0x11 bit 10.
- speed, output, 2: status reg 0x11 bits 15:14 (00 = 10M, 01 = 100M, 10 = 1000M).
- timeout_err, output, 1: sticky; set on any handshake timeout.
- id_err, output, 1: sticky; set on ID mismatch (see Configuration).

## Operation
- Reset values: phy_rstn 0, reset_n_done 0, start 0, opcode 2'b00, reg_addr 0, write_data 0, init_done 0, link_up 0, speed 2'b00, timeout_err 0, id_err 0.
- ready passes through a 2-flop synchronizer (ready_s) before use.
- Top FSM:
  - RST_LOW: hold phy_rstn low for RST_LOW_CYCLES.
  - RST_WAIT: phy_rstn=1; wait RST_WAIT_CYCLES.
  - ID_CHECK: present only when the macro is defined.
  - INIT: reset_n_done=1; run entries 0..2 in order.
  - POLL_WAIT: idle for POLL_CYCLES.
  - POLL: issue a read of reg 0x11, then return to POLL_WAIT.
- Init table, all writes, fixed order:
  - reg 0x04 = 16'h01E1
  - reg 0x09 = 16'h0200
  - reg 0x00 = 16'h1340
- init_done rises on completion of entry 2 and stays high until reset.
- Transaction sub-FSM: T_IDLE → T_ARM → T_BUSY → T_DONE.
  - T_ARM: wait for ready_s=1, then load opcode, reg_addr and write_data and assert start.
  - T_BUSY: hold start until ready_s=0, then deassert start.
  - T_DONE: wait for ready_s 0→1. On completion of a read, capture read_data in that same cycle.
- opcode, reg_addr and write_data stay stable from start assertion until completion.
- Timeout: the phase counter resets on each sub-state entry. Reaching TIMEOUT_CYCLES in T_BUSY or T_DONE does four things:
  - sets timeout_err,
  - drops start,
  - returns to T_ARM,
  - retries the same entry. There is no retry limit.
- Poll result: link_up and speed update only from a completed read. A timed-out poll leaves both unchanged.
- Reset mid-transaction: all state returns to reset values immediately; phy_rstn drops low.

## Timing
- Write transaction: roughly 65 mdc cycles plus 2–3 synchronizer clk cycles, about 330 clk total.
- start is high for at least 2 mdc periods (10 clk), so the driver's posedge-mdc edge detector sees it.
- reset_n_done rises 1 clk after RST_WAIT expires. The first start is no earlier than ready_s=1.
- link_up and speed register 1 clk after the completing ready_s edge.
- Minimum gap between transactions: 1 clk in T_IDLE plus re-arm.

## Configuration
- PHY_ID_CHECK_EN defined: ID_CHECK reads reg 0x02 before INIT.
  - Result 16'h4F51: proceed to INIT.
  - Any other value: set id_err and halt in ERR_HALT (start stays 0, init_done stays 0).
- PHY_ID_CHECK_EN undefined: ID_CHECK state and id_err logic are absent; id_err is tied to 0 and RST_WAIT goes straight to INIT.

## Test plan
- Reset release with a driver model that answers ready → phy_rstn rises after RST_LOW_CYCLES; reset_n_done rises RST_WAIT_CYCLES later; three writes appear in order (0x04/01E1, 0x09/0200, 0x00/1340); init_done=1.
- Poll returns 16'h8400 → link_up=1, speed=2'b10. Next poll returns 16'h0000 → link_up=0, speed=2'b00.
- ready held high (driver stuck) during entry 1 → after TIMEOUT_CYCLES, timeout_err=1 and entry 1 reissues; releasing the stuck ready lets init complete.
- rstn pulsed low during entry 2 in T_BUSY → start=0 and phy_rstn=0 asynchronously; the full sequence restarts from entry 0.
- With PHY_ID_CHECK_EN, ID read returns 16'h4F51 → init proceeds. ID read returns 16'h1234 → id_err=1 with no further start pulses.
- Opcode/address/data stability: check that opcode, reg_addr and write_data hold constant from start assertion until the ready_s rising edge across all transactions.
